// File: rtl/sd_pkg.sv
// Shared types and helpers for the SD-card access arbiter.
// Holds the FSM state encoding and the round-robin pick function.
package sd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    OWNED,
    READING,
    RELEASE
  } sd_state_e;

  localparam int SD_BLOCK_W = 32;
  localparam int RR_MAX     = 16;

  // One-hot of the first set bit of req, scanning up from last+1, wrapping at n.
  function automatic logic [RR_MAX-1:0] rr_pick(
    input logic [RR_MAX-1:0] req,
    input int                n,
    input int                last
  );
    logic [RR_MAX-1:0] pick;
    logic              found;
    logic [3:0]        idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= RR_MAX; k++) begin
      idx = 4'((last + k) % n);
      if (k <= n && !found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/sd_rr_picker.sv
// Combinational round-robin selector: one-hot winner after index last.
// valid is high whenever any request bit is set.
module sd_rr_picker
  import sd_pkg::*;
#(
  parameter int N  = 6,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  pick,
  output logic          valid
);

  logic [RR_MAX-1:0] req_x;
  logic [RR_MAX-1:0] pick_x;

  always_comb begin
    req_x         = '0;
    req_x[N-1:0]  = req;
    pick_x        = rr_pick(req_x, N, int'(last));
    pick          = pick_x[N-1:0];
    valid         = |pick_x;
  end

endmodule

// File: rtl/sd_access_arbiter.sv
// Round-robin owner arbitration for the shared SD block reader.
// Forwards the owner's read as a one-cycle command and reclaims idle owners.
module sd_access_arbiter
  import sd_pkg::*;
#(
  parameter int N        = 6,
  parameter int HOLD_MAX = 1000000,
  parameter int HOLD_W   = $clog2(HOLD_MAX + 1)
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [N-1:0]            Request,
  output logic [N-1:0]            Grant,
  input  logic [SD_BLOCK_W*N-1:0] Block,
  input  logic [N-1:0]            Read,
  output logic [N-1:0]            Done,
  output logic                    Timeout,
  output logic [SD_BLOCK_W-1:0]   SD_Block,
  output logic                    SD_Read,
  input  logic                    SD_Busy,
  input  logic                    SD_Error,
  output logic                    Error
);

  localparam int IW = $clog2(N);

  sd_state_e             state_q, state_d;
  logic [IW-1:0]         last_q, last_d;
  logic [IW-1:0]         owner_q, owner_d;
  logic [N-1:0]          grant_q, grant_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic                  seen_busy_q, seen_busy_d;
  logic [N-1:0]          done_q, done_d;
  logic                  timeout_q, timeout_d;
  logic                  sd_read_q, sd_read_d;
  logic [SD_BLOCK_W-1:0] sd_block_q, sd_block_d;
  logic                  err_q, err_d;

  logic [SD_BLOCK_W-1:0] blk [N];
  logic [IW-1:0]         rr_last;
  logic [N-1:0]          pick;
  logic                  pick_v;
  logic [IW-1:0]         pick_idx;

  for (genvar i = 0; i < N; i++) begin : g_blk
    assign blk[i] = Block[i*SD_BLOCK_W +: SD_BLOCK_W];
  end

  // Leaving RELEASE arbitrates from the outgoing owner so only one dead cycle.
  assign rr_last = (state_q == RELEASE) ? owner_q : last_q;

  sd_rr_picker #(.N(N), .IW(IW)) u_pick (
    .req   (Request),
    .last  (rr_last),
    .pick  (pick),
    .valid (pick_v)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (pick[i]) pick_idx = IW'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    grant_d     = grant_q;
    hold_d      = hold_q;
    seen_busy_d = seen_busy_q;
    done_d      = '0;
    timeout_d   = 1'b0;
    sd_read_d   = 1'b0;
    sd_block_d  = sd_block_q;
    err_d       = err_q | SD_Error;
    unique case (state_q)
      IDLE: begin
        if (!err_q && pick_v) begin
          grant_d = pick;
          owner_d = pick_idx;
          hold_d  = '0;
          state_d = OWNED;
        end
      end
      OWNED: begin
        if (SD_Error || !Request[owner_q]) begin
          grant_d = '0;
          state_d = RELEASE;
        end else if (Read[owner_q] && !SD_Busy) begin
          sd_block_d  = blk[owner_q];
          sd_read_d   = 1'b1;
          seen_busy_d = 1'b0;
          state_d     = READING;
        end else if (hold_q == HOLD_W'(HOLD_MAX)) begin
          timeout_d = 1'b1;
          grant_d   = '0;
          state_d   = RELEASE;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      READING: begin
        if (SD_Error) begin
          grant_d = '0;
          state_d = RELEASE;
        end else if (seen_busy_q && !SD_Busy) begin
          done_d  = grant_q;
          hold_d  = '0;
          state_d = OWNED;
        end else if (SD_Busy) begin
          seen_busy_d = 1'b1;
        end
      end
      RELEASE: begin
        last_d  = owner_q;
        state_d = IDLE;
        if (!err_q && pick_v) begin
          grant_d = pick;
          owner_d = pick_idx;
          hold_d  = '0;
          state_d = OWNED;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      last_q      <= IW'(N - 1);
      owner_q     <= '0;
      grant_q     <= '0;
      hold_q      <= '0;
      seen_busy_q <= 1'b0;
      done_q      <= '0;
      timeout_q   <= 1'b0;
      sd_read_q   <= 1'b0;
      sd_block_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      grant_q     <= grant_d;
      hold_q      <= hold_d;
      seen_busy_q <= seen_busy_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      sd_read_q   <= sd_read_d;
      sd_block_q  <= sd_block_d;
      err_q       <= err_d;
    end
  end

  assign Grant    = grant_q;
  assign Done     = done_q;
  assign Timeout  = timeout_q;
  assign SD_Read  = sd_read_q;
  assign SD_Block = sd_block_q;
  assign Error    = err_q;

endmodule

// File: tb/tb_sd_access_arbiter.sv
// Scoreboard bench for sd_access_arbiter: directed scenarios plus random traffic.
// A cycle-level reference model queues expected events; a monitor pops them.
module tb_sd_access_arbiter;

  localparam int N  = 6;
  localparam int HM = 16;

  logic            Clk = 1'b0;
  logic            Reset = 1'b0;
  logic [N-1:0]    Request = '0;
  logic [N-1:0]    Read = '0;
  logic [32*N-1:0] Block;
  logic [31:0]     blk_arr [N];
  logic            SD_Busy = 1'b0;
  logic            SD_Error = 1'b0;
  logic [N-1:0]    Grant;
  logic [N-1:0]    Done;
  logic            Timeout;
  logic [31:0]     SD_Block;
  logic            SD_Read;
  logic            Error;

  for (genvar gi = 0; gi < N; gi++) begin : g_blk
    assign Block[gi*32 +: 32] = blk_arr[gi];
  end

  always #5 Clk = ~Clk;

  sd_access_arbiter #(.N(N), .HOLD_MAX(HM)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Request  (Request),
    .Grant    (Grant),
    .Block    (Block),
    .Read     (Read),
    .Done     (Done),
    .Timeout  (Timeout),
    .SD_Block (SD_Block),
    .SD_Read  (SD_Read),
    .SD_Busy  (SD_Busy),
    .SD_Error (SD_Error),
    .Error    (Error)
  );

  typedef struct {
    int          cyc;
    logic [31:0] val;
  } ev_t;

  ev_t gq[$], rq[$], dq[$], tq[$], eq[$];
  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  int  blen = 20;
  int  rst_count = 0;

  task automatic chk(input bit ok, input string nm,
                     input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int M_IDLE = 0, M_OWN = 1, M_RD = 2, M_REL = 3;
  int m_mode = M_IDLE, m_last = N - 1, m_owner = 0, m_hold = 0;
  bit m_seen = 0, m_err = 0;
  int m_rst_seen = 0;

  function automatic int rr_ref(input int last);
    for (int k = 1; k <= N; k++) begin
      if (Request[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic grant_to(input int p);
    m_owner = p;
    m_hold  = 0;
    m_mode  = M_OWN;
    gq.push_back('{cyc, 32'(1) << p});
  endtask

  task automatic drop();
    m_mode = M_REL;
    gq.push_back('{cyc, 32'(0)});
  endtask

  task automatic model_step();
    int p;
    bit nerr;
    nerr = m_err | SD_Error;
    case (m_mode)
      M_IDLE: if (!m_err) begin
        p = rr_ref(m_last);
        if (p >= 0) grant_to(p);
      end
      M_OWN: begin
        if (SD_Error || !Request[m_owner]) drop();
        else if (Read[m_owner] && !SD_Busy) begin
          rq.push_back('{cyc, blk_arr[m_owner]});
          m_seen = 0;
          m_mode = M_RD;
        end else if (m_hold == HM) begin
          tq.push_back('{cyc, 32'(1)});
          drop();
        end else m_hold++;
      end
      M_RD: begin
        if (SD_Error) drop();
        else if (m_seen && !SD_Busy) begin
          dq.push_back('{cyc, 32'(1) << m_owner});
          m_hold = 0;
          m_mode = M_OWN;
        end else if (SD_Busy) m_seen = 1;
      end
      default: begin
        m_last = m_owner;
        m_mode = M_IDLE;
        if (!m_err) begin
          p = rr_ref(m_last);
          if (p >= 0) grant_to(p);
        end
      end
    endcase
    if (nerr && !m_err) eq.push_back('{cyc, 32'(1)});
    m_err = nerr;
  endtask

  initial forever begin
    @(posedge Clk);
    cyc++;
    if (m_rst_seen != rst_count) begin
      m_rst_seen = rst_count;
      m_mode = M_IDLE; m_last = N - 1; m_hold = 0; m_seen = 0; m_err = 0;
    end
    if (Reset) model_step();
  end

  // ---------------- card reader busy emulation ----------------
  int b_left = 0;
  bit b_pend = 0;
  int b_rst_seen = 0;

  initial forever begin
    @(posedge Clk);
    #1;
    if (b_rst_seen != rst_count) begin
      b_rst_seen = rst_count;
      SD_Busy = 0; b_left = 0; b_pend = 0;
    end
    if (SD_Busy) begin
      b_left--;
      if (b_left <= 0) SD_Busy = 0;
    end else if (b_pend) begin
      b_pend = 0; SD_Busy = 1; b_left = blen;
    end
    if (SD_Read) begin
      if ($urandom_range(0, 1) == 1) begin
        SD_Busy = 1; b_left = blen;
      end else b_pend = 1;
    end
  end

  // ---------------- monitor ----------------
  logic [N-1:0] mon_gnt = '0;
  logic         mon_err = 1'b0;
  int           mon_rst_seen = 0;

  task automatic pop_cmp(input string nm, input int which, input logic [31:0] act);
    ev_t e;
    bit  empty;
    case (which)
      0: empty = (gq.size() == 0);
      1: empty = (rq.size() == 0);
      2: empty = (dq.size() == 0);
      3: empty = (tq.size() == 0);
      default: empty = (eq.size() == 0);
    endcase
    if (empty) begin
      chk(1'b0, {nm, "_unexpected"}, act, 32'hx);
      return;
    end
    case (which)
      0: e = gq.pop_front();
      1: e = rq.pop_front();
      2: e = dq.pop_front();
      3: e = tq.pop_front();
      default: e = eq.pop_front();
    endcase
    chk(e.cyc == cyc, {nm, "_cycle"}, 32'(cyc), 32'(e.cyc));
    chk(e.val == act, {nm, "_value"}, act, e.val);
  endtask

  initial forever begin
    @(negedge Clk);
    if (mon_rst_seen != rst_count) begin
      mon_rst_seen = rst_count;
      mon_gnt = '0;
      mon_err = 1'b0;
    end
    if (Reset) begin
      if (Grant !== mon_gnt) begin
        chk($onehot0(Grant), "grant_onehot", 32'(Grant), 32'(0));
        pop_cmp("grant", 0, 32'(Grant));
        mon_gnt = Grant;
      end
      if (SD_Read) pop_cmp("sd_read", 1, SD_Block);
      if (Done != '0) pop_cmp("done", 2, 32'(Done));
      if (Timeout) pop_cmp("timeout", 3, 32'(Timeout));
      if (Error !== mon_err) begin
        pop_cmp("error", 4, 32'(Error));
        mon_err = Error;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  function automatic bit cond(input int kind);
    case (kind)
      0: return Grant != '0;
      1: return SD_Read;
      2: return Done != '0;
      default: return Timeout;
    endcase
  endfunction

  task automatic wait_until(input int kind, input int lim, output bit ok);
    ok = 0;
    for (int i = 0; i < lim; i++) begin
      if (cond(kind)) begin
        ok = 1;
        return;
      end
      step(1);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    chk(Grant == '0, {tag, "_grant"}, 32'(Grant), 0);
    chk(Done == '0, {tag, "_done"}, 32'(Done), 0);
    chk(Timeout == 0, {tag, "_timeout"}, 32'(Timeout), 0);
    chk(SD_Read == 0, {tag, "_sd_read"}, 32'(SD_Read), 0);
    chk(SD_Block == 0, {tag, "_sd_block"}, SD_Block, 0);
    chk(Error == 0, {tag, "_error"}, 32'(Error), 0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge Clk);
    #1;
    Reset = 0;
    SD_Error = 0;
    rst_count++;
    #1;
    check_zero_outputs(tag);
    Reset = 1;
  endtask

  task automatic serve(output int who);
    bit ok;
    who = -1;
    wait_until(0, 50, ok);
    chk(ok, "serve_wait_grant", 32'(Grant), 32'h1);
    for (int i = 0; i < N; i++) if (Grant[i]) who = i;
    if (who < 0) return;
    Read[who] = 1'b1;
    wait_until(1, 20, ok);
    chk(ok, "serve_wait_sd_read", 32'(SD_Read), 1);
    Read[who] = 1'b0;
    wait_until(2, 60, ok);
    chk(ok, "serve_wait_done", 32'(Done), 32'(1) << who);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench did not finish");
  end

  // ---------------- test sequence ----------------
  initial begin
    bit ok;
    int who, z, bad, gc;
    int order[$];
    for (int i = 0; i < N; i++) blk_arr[i] = '0;
    repeat (2) @(posedge Clk);
    #1;
    check_zero_outputs("reset");
    @(negedge Clk);
    Reset = 1;

    // single requester
    Request = 6'b000100;
    step(1);
    chk(Grant == 6'b000100, "t1_grant_latency", 32'(Grant), 32'h4);
    Read[2] = 1'b1;
    blk_arr[2] = 32'h0000_1234;
    blen = 20;
    wait_until(1, 20, ok);
    chk(ok, "t1_sd_read_seen", 32'(SD_Read), 1);
    chk(SD_Block == 32'h1234, "t1_sd_block", SD_Block, 32'h1234);
    Read[2] = 1'b0;
    wait_until(2, 60, ok);
    chk(Done == 6'b000100, "t1_done", 32'(Done), 32'h4);
    Request = '0;
    step(3);

    // fairness
    do_reset("fair_reset");
    Request = '1;
    blen = 3;
    for (int k = 0; k < 7; k++) begin
      serve(who);
      order.push_back(who);
      if (k < 6) begin
        if (who >= 0) Request[who] = 1'b0;
        step(1);
        if (who >= 0) Request[who] = 1'b1;
        z = 0;
        while (Grant == '0 && z < 10) begin
          z++;
          step(1);
        end
        chk(z == 1, "fair_dead_cycles", 32'(z), 1);
      end
    end
    Request = '0;
    for (int k = 0; k < 7; k++)
      chk(order[k] == k % N, "fair_order", 32'(order[k]), 32'(k % N));
    step(4);

    // request dropped mid-transfer
    Request = 6'b000010;
    blen = 20;
    wait_until(0, 10, ok);
    Read[1] = 1'b1;
    wait_until(1, 20, ok);
    chk(ok, "t3_sd_read_seen", 32'(SD_Read), 1);
    Read[1] = 1'b0;
    step(3);
    Request[1] = 1'b0;
    bad = 0;
    for (int i = 0; i < 60 && Done == '0; i++) begin
      if (Grant != 6'b000010) bad++;
      step(1);
    end
    chk(Done == 6'b000010, "t3_done", 32'(Done), 32'h2);
    chk(bad == 0, "t3_grant_held", 32'(bad), 0);
    step(1);
    chk(Grant == '0, "t3_grant_released", 32'(Grant), 0);
    step(2);

    // watchdog
    Request = 6'b010000;
    wait_until(0, 10, ok);
    gc = cyc;
    wait_until(3, 40, ok);
    chk(ok && (cyc - gc == HM + 1), "t4_timeout_cycle", 32'(cyc - gc), 32'(HM + 1));
    chk(Grant == '0, "t4_grant_dropped", 32'(Grant), 0);
    step(1);
    chk(Grant == 6'b010000, "t4_regrant", 32'(Grant), 32'h10);
    Request = '0;
    step(3);

    // sticky error
    do_reset("err_reset");
    Request = '1;
    wait_until(0, 10, ok);
    chk(Grant == 6'b000001, "t5_first_grant", 32'(Grant), 32'h1);
    Read[0] = 1'b1;
    wait_until(1, 20, ok);
    Read[0] = 1'b0;
    step(3);
    SD_Error = 1'b1;
    step(1);
    chk(Grant == '0, "t5_grant_drop", 32'(Grant), 0);
    chk(Error == 1'b1, "t5_error", 32'(Error), 1);
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (Grant != '0 || Done != '0) bad++;
    end
    chk(bad == 0, "t5_no_grants", 32'(bad), 0);
    do_reset("err_clear");
    step(1);
    chk(Grant == 6'b000001, "t5_grant_after_reset", 32'(Grant), 32'h1);

    // async reset in the middle of a read
    Read[0] = 1'b1;
    wait_until(1, 20, ok);
    Read[0] = 1'b0;
    step(5);
    do_reset("t6_async");
    step(1);
    chk(Grant == 6'b000001, "t6_restart_from_0", 32'(Grant), 32'h1);
    Request = '0;
    step(25);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 15) == 0) Request[i] = ~Request[i];
        Read[i] = ($urandom_range(0, 3) == 0);
        blk_arr[i] = $urandom;
      end
      blen = $urandom_range(1, 6);
      step(1);
    end
    Request = '0;
    Read = '0;
    step(40);

    chk(gq.size() == 0, "left_grant_events", 32'(gq.size()), 0);
    chk(rq.size() == 0, "left_read_events", 32'(rq.size()), 0);
    chk(dq.size() == 0, "left_done_events", 32'(dq.size()), 0);
    chk(tq.size() == 0, "left_timeout_events", 32'(tq.size()), 0);
    chk(eq.size() == 0, "left_error_events", 32'(eq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sd_access_arbiter.md
Name: sd_access_arbiter

Overview:
- Round-robin access controller for the single SD-card block reader, shared between N requesters (audio streamer, file-system walker, config loader, ...).
- Grants exclusive ownership and forwards the owner's block number and read strobe as a one-cycle command.
- Never revokes ownership mid-transfer. Reports per-requester completion and reclaims the card from owners that hold it idle too long.
- Sits between the requesting clients and the SD card reader, replacing the bare mutex-plus-OR-mux arrangement.

Parameters:
- N, 6, number of requesters (2..16).
- HOLD_MAX, 1000000, max cycles an owner may hold the card in OWNED without issuing a read.
- HOLD_W, $clog2(HOLD_MAX+1), hold-counter width.

Ports:
- Clk  input  1  system clock; all logic on rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Request  input  N  per-requester ownership request, level; held while ownership is wanted.
- Grant  output  N  one-hot (or zero) registered ownership.
- Block  input  32*N  packed block numbers; requester i uses bits [32*i+31:32*i].
- Read  input  N  per-requester read request, level; sampled only for the owner.
- Done  output  N  one-cycle pulse to the owner when its block read finishes.
- Timeout  output  1  one-cycle pulse when an owner is reclaimed by the watchdog.
- SD_Block  output  32  registered block number to the card reader.
- SD_Read  output  1  one-cycle read strobe to the card reader.
- SD_Busy  input  1  card reader busy; rises within 2 cycles after SD_Read, falls when the block has been written out.
- SD_Error  input  1  card reader error flag, sticky until the reader is reset.
- Error  output  1  registered copy of the latched error; stays high until Reset.

Behaviour:
- Reset (Reset=0, asynchronous):
  - Grant=0, Done=0, Timeout=0, SD_Read=0, SD_Block=0, Error=0.
  - State=IDLE, Last=N-1, hold counter=0, seen_busy=0.
- IDLE:
  - If Error, stay in IDLE.
  - Else, if any Request bit is set, pick the first set bit scanning upward from (Last+1) mod N, wrapping. Grant that bit on the next edge, clear the hold counter, go to OWNED.
  - Request-to-Grant latency is 1 cycle.
- OWNED (owner g):
  - Priority 1: if SD_Error, go to RELEASE.
  - Priority 2: if Request[g]=0, go to RELEASE.
  - Priority 3: if Read[g]=1 and SD_Busy=0, latch SD_Block=Block[g] and pulse SD_Read for exactly 1 cycle. Clear seen_busy and go to READING.
  - Priority 4: if the hold counter equals HOLD_MAX, pulse Timeout and go to RELEASE.
  - Otherwise increment the hold counter, saturating at HOLD_MAX.
- READING:
  - Set seen_busy when SD_Busy=1.
  - When seen_busy=1 and SD_Busy=0: pulse Done[g] for 1 cycle, clear the hold counter, return to OWNED.
  - Request[g] falling during READING is ignored until Done; the grant is never dropped mid-transfer.
  - If SD_Error rises, go to RELEASE without Done.
  - The hold watchdog does not run in READING.
- RELEASE:
  - Grant=0 for exactly 1 cycle; Last=g; go to IDLE.
  - This guarantees at least one dead cycle between owners, and SD_Block/SD_Read are never driven on behalf of a stale owner.
- Error:
  - Set on any cycle where SD_Error=1.
  - Once set, no new grants are issued until Reset.
- Read held high by the owner after Done starts a new read on the next OWNED cycle (back-to-back streaming allowed). Each read costs at least 2 cycles of arbitration overhead.
- Read and Block from non-owners are ignored. SD_Block changes only with SD_Read.
- Done and Timeout are mutually exclusive on any cycle. Grant is always one-hot or zero.

Decomposition:
- Package sd_pkg holds:
  - the state enum (IDLE, OWNED, READING, RELEASE);
  - the SD_BLOCK_W=32 constant;
  - a function rr_pick(req, last) returning a one-hot vector.
- One natural sub-module: sd_rr_picker, a combinational round-robin priority selector (N-bit request, last index, one-hot out, valid).

Test Plan:
- Single requester: Request[2]=1 at cycle 0 gives Grant=6'b000100 at cycle 1. With Read[2]=1 and Block slice 2=32'h0000_1234: SD_Read pulses once with SD_Block=32'h1234. The bench's Busy model gives 20 cycles busy, after which Done[2] pulses once.
- Fairness: Request=6'b111111 held, each owner does one read then drops Request for 1 cycle. Grant order must be 0,1,2,3,4,5,0, with exactly 1 zero-grant cycle between owners.
- Drop mid-transfer: Request[1] falls 3 cycles after SD_Read. Grant[1] must stay high until Done[1], then Grant=0 for 1 cycle.
- Watchdog: HOLD_MAX=16, Request[4]=1 with Read=0. Timeout must pulse at cycle 1+17 relative to grant, then Grant=0, then Grant[4] is re-issued if Request[4] is still high and no one else is requesting.
- Error: SD_Error=1 during READING. Grant must go to 0 within 2 cycles, with no Done and Error=1. No further grants while Request=6'b111111, until Reset is pulsed low.
- Async reset mid-read: Reset low for 1 ns between edges. All outputs must be 0 immediately, and arbitration restarts from requester 0.
